imm_shift_sequencer: RTL and testbench

- Multi-cycle controller that sequences the immediate-shift datapath.
- Accepts a 16-bit immediate plus an operation, then extends it to 32 bits.
- Shifts the value one bit per clock until the requested amount is reached, then presents the result on a valid/ready output handshake.
- Serves LUI (fixed shift of 16) and variable immediate shifts for the multi-cycle execute path, replacing the unrolled combinational shifter where area matters.

---
 rtl/imm_shift_sequencer_pkg.sv | 20 ++
 rtl/imm_shift_sequencer_extend.sv | 14 +
 rtl/imm_shift_sequencer.sv | 94 +++++++++
 tb/tb_imm_shift_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_shift_sequencer_pkg.sv
// Shared encodings for the serial immediate-shift sequencer.
// Mode and state enums plus the fixed LUI shift distance.
package imm_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_LUI  = 2'b00,
    MODE_SLL  = 2'b01,
    MODE_SLLS = 2'b10,
    MODE_SRL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int LUI_SHAMT = 16;

endpackage

// File: rtl/imm_shift_sequencer_extend.sv
// Zero/sign extension of an immediate to the datapath width.
// Purely combinational; no handshake.
module imm_extend #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] ext_o
);

  assign ext_o = {{(DATA_W-IMM_W){sign_i & imm_i[IMM_W-1]}}, imm_i};

endmodule

// File: rtl/imm_shift_sequencer.sv
// Serial immediate shifter: one bit per clock, result valid N cycles after accept.
// Result held stable in DONE until res_ready; abort returns to IDLE without counting.
module imm_shift_sequencer
  import imm_shift_sequencer_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [IMM_W-1:0]   imm,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               busy,
  output logic [CNT_W-1:0]   done_count
);

  state_e             state_q;
  logic [DATA_W-1:0]  acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_right_q;
  logic [CNT_W-1:0]   done_cnt_q;

  logic [DATA_W-1:0]  ext_d;
  logic [SHAMT_W-1:0] cnt_d;

  imm_extend #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_extend (
    .imm_i  (imm),
    .sign_i (mode == MODE_SLLS),
    .ext_o  (ext_d)
  );

  assign cnt_d = (mode == MODE_LUI) ? SHAMT_W'(LUI_SHAMT) : shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            acc_q       <= ext_d;
            cnt_q       <= cnt_d;
            dir_right_q <= (mode == MODE_SRL);
            state_q     <= (cnt_d != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          // acc is left as-is on abort; the next accept overwrites it
          if (abort) begin
            state_q <= IDLE;
          end else begin
            acc_q <= dir_right_q ? (acc_q >> 1) : (acc_q << 1);
            cnt_q <= cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
            state_q    <= IDLE;
          end else if (abort) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_data    = acc_q;
  assign done_count  = done_cnt_q;

endmodule

// File: tb/tb_imm_shift_sequencer.sv
// Self-checking bench: directed cases plus randomized traffic against a
// deadline-based reference model of the sequencer.
module tb_imm_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [7:0]  done_count;

  int checks = 0;
  int errors = 0;

  imm_shift_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .imm         (imm),
    .mode        (mode),
    .shamt       (shamt),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .done_count  (done_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields a known result that
  // becomes visible a fixed number of edges after acceptance.
  bit          m_active;
  int          m_cnt;
  longint      cyc;
  longint      m_rdy_cyc;
  logic [31:0] m_res;
  logic [31:0] m_ext;
  int          m_n;

  function automatic bit m_vld();
    return m_active && (cyc >= m_rdy_cyc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      m_cnt     = 0;
      cyc       = 0;
      m_rdy_cyc = 0;
      m_res     = 32'h0;
    end else begin
      if (!m_active) begin
        if (start_valid) begin
          m_n       = (mode == 2'b00) ? 16 : int'(shamt);
          m_ext     = (mode == 2'b10) ? {{16{imm[15]}}, imm} : {16'h0, imm};
          m_res     = (mode == 2'b11) ? (m_ext >> m_n) : (m_ext << m_n);
          m_rdy_cyc = cyc + 1 + longint'(m_n);
          m_active  = 1'b1;
        end
      end else if (m_vld() && res_ready) begin
        m_cnt++;
        m_active = 1'b0;
      end else if (abort) begin
        m_active = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("res_valid", 32'(res_valid), 32'(m_vld()));
    check("start_ready", 32'(start_ready), 32'(!m_active));
    check("busy", 32'(busy), 32'(m_active));
    check("done_count", 32'(done_count), 32'(m_cnt[7:0]));
    if (m_vld()) check("res_data", res_data, m_res);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [15:0] i, input logic [1:0] m, input logic [4:0] s);
    int n = 0;
    while (!start_ready && n < 100) begin
      step();
      n++;
    end
    if (!start_ready) check("req_timeout", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    imm = i;
    mode = m;
    shamt = s;
    step();
    start_valid = 1'b0;
    imm   = 16'($urandom);
    mode  = 2'($urandom);
    shamt = 5'($urandom);
  endtask

  // Returns edges counted from the accept edge (inclusive) to res_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 100) begin
      step();
      lat++;
    end
    if (!res_valid) check("valid_timeout", 32'(res_valid), 32'd1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    imm = 16'h0;
    mode = 2'b00;
    shamt = 5'h0;
    abort = 1'b0;
    res_ready = 1'b0;
    repeat (3) step();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_done_count", 32'(done_count), 32'd0);
    rst_n = 1'b1;
    step();

    res_ready = 1'b1;
    do_req(16'h1234, 2'b00, 5'd7);
    wait_valid(lat);
    check("lui_lat", 32'(lat), 32'd17);
    check("lui_data", res_data, 32'h12340000);
    step();
    check("lui_count", 32'(done_count), 32'd1);

    do_req(16'hFFFF, 2'b01, 5'd0);
    check("sll0_busy", 32'(busy), 32'd1);
    check("sll0_valid", 32'(res_valid), 32'd1);
    check("sll0_data", res_data, 32'h0000FFFF);
    step();
    check("sll0_busy_after", 32'(busy), 32'd0);

    do_req(16'h8001, 2'b10, 5'd4);
    wait_valid(lat);
    check("slls_lat", 32'(lat), 32'd5);
    check("slls_data", res_data, 32'hFFF80010);
    step();

    do_req(16'h8000, 2'b11, 5'd15);
    wait_valid(lat);
    check("srl_lat", 32'(lat), 32'd16);
    check("srl_data", res_data, 32'h00000001);
    step();

    do_req(16'h0001, 2'b01, 5'd31);
    wait_valid(lat);
    check("sll31_data", res_data, 32'h80000000);
    step();
    check("count_5", 32'(done_count), 32'd5);

    res_ready = 1'b0;
    do_req(16'hABCD, 2'b00, 5'd0);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_data", res_data, 32'hABCD0000);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      step();
    end
    check("bp_count_hold", 32'(done_count), 32'd5);
    res_ready = 1'b1;
    step();
    check("bp_count", 32'(done_count), 32'd6);
    check("bp_valid_drop", 32'(res_valid), 32'd0);

    do_req(16'h5555, 2'b00, 5'd0);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_ready", 32'(start_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      check("abort_no_valid", 32'(res_valid), 32'd0);
      step();
    end
    check("abort_count", 32'(done_count), 32'd6);
    do_req(16'h0003, 2'b01, 5'd1);
    wait_valid(lat);
    check("post_abort_data", res_data, 32'h00000006);
    step();
    check("post_abort_count", 32'(done_count), 32'd7);

    do_req(16'hBEEF, 2'b00, 5'd0);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_ready", 32'(start_ready), 32'd1);
    check("arst_data", res_data, 32'h0);
    check("arst_count", 32'(done_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_req(16'h0001, 2'b00, 5'd3);
    wait_valid(lat);
    check("arst_lui_data", res_data, 32'h00010000);
    step();

    for (int k = 0; k < 3000; k++) begin
      start_valid = ($urandom_range(0, 2) != 0);
      imm         = 16'($urandom);
      mode        = 2'($urandom);
      shamt       = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 8));
      res_ready   = ($urandom_range(0, 2) != 0);
      abort       = ($urandom_range(0, 15) == 0);
      step();
    end
    start_valid = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
